// File: rtl/blit_pkg.sv
// ---------------------------------------------------------------------------
// blit_pkg
// Shared definitions for the screen blitter:
//   - blit_state_e : controller states (IDLE, DRAW, FLUSH, DONE)
//   - DEF_*        : default resolution, colour depth and image count
//   - width_of()   : counter width helper that never returns zero
// No ports (package).
// ---------------------------------------------------------------------------
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

  localparam int DEF_H_RES    = 160;
  localparam int DEF_V_RES    = 120;
  localparam int DEF_COLOUR_W = 9;
  localparam int DEF_NUM_IMG  = 4;

  // A single-valued range still needs a one-bit signal to carry it.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// ---------------------------------------------------------------------------
// blit_addr_gen
// Raster-order pixel counters for the blitter. Keeps the column, the row and
// the linear ROM address (y*H_RES+x) in step without a multiplier.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset, clears all counters
//   clear_i  in   restart the raster at (0,0), address 0
//   step_i   in   advance one pixel (ignored on the final pixel)
//   x_o      out  current column
//   y_o      out  current row
//   addr_o   out  current linear address
//   last_o   out  high while the counters sit on (H_RES-1, V_RES-1)
// ---------------------------------------------------------------------------
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                clear_i,
  input  logic                                step_i,
  output logic [width_of(H_RES)-1:0]          x_o,
  output logic [width_of(V_RES)-1:0]          y_o,
  output logic [width_of(H_RES*V_RES)-1:0]    addr_o,
  output logic                                last_o
);

  localparam int XW = width_of(H_RES);
  localparam int YW = width_of(V_RES);
  localparam int AW = width_of(H_RES * V_RES);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          lastPixel;
  logic          endOfRow;

  assign endOfRow  = (x_q == XW'(H_RES - 1));
  assign lastPixel = endOfRow && (y_q == YW'(V_RES - 1));

  // Next-pixel logic. The counters freeze on the final pixel so the address
  // can never run past the end of the image, whatever the controller does.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (step_i && !lastPixel) begin
      addr_d = addr_q + 1'b1;
      if (endOfRow) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = lastPixel;

endmodule

// File: rtl/screen_blitter.sv
// ---------------------------------------------------------------------------
// screen_blitter
// Full-screen image blitter for the VGA adapter. A start pulse in IDLE
// latches the image index, then every pixel address is issued to the external
// ROMs in raster order. Pixel coordinates travel down a ROM_LAT-deep delay
// line so that x/y/colour/plot leave the block aligned with the ROM data.
// Optional feature macro: BLIT_TRANSPARENT_EN -- pixels whose ROM colour
// equals KEY_COL are not plotted, letting images overlay the framebuffer.
// Ports:
//   clk_i       in   system clock
//   reset_i     in   synchronous active-high reset, aborts a frame at once
//   start_i     in   draw request, only honoured in IDLE
//   img_sel_i   in   image index, latched on an accepted start
//   busy_o      out  high from accepted start until the done pulse
//   done_o      out  one-cycle pulse once the last pixel has been plotted
//   rom_addr_o  out  linear pixel address y*H_RES+x
//   rom_sel_o   out  latched (clamped) image index for the ROM mux
//   rom_data_i  in   ROM data, valid ROM_LAT clocks after rom_addr_o
//   x_o, y_o    out  pixel coordinates to the VGA adapter
//   colour_o    out  pixel colour to the VGA adapter
//   plot_o      out  registered write enable to the VGA adapter
// ---------------------------------------------------------------------------
module screen_blitter
  import blit_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int NUM_IMG  = DEF_NUM_IMG,
  parameter int ROM_LAT  = 1,
  parameter int KEY_COL  = 0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [width_of(NUM_IMG)-1:0]      img_sel_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [width_of(H_RES*V_RES)-1:0]  rom_addr_o,
  output logic [width_of(NUM_IMG)-1:0]      rom_sel_o,
  input  logic [COLOUR_W-1:0]               rom_data_i,
  output logic [width_of(H_RES)-1:0]        x_o,
  output logic [width_of(V_RES)-1:0]        y_o,
  output logic [COLOUR_W-1:0]               colour_o,
  output logic                              plot_o
);

  localparam int XW = width_of(H_RES);
  localparam int YW = width_of(V_RES);
  localparam int AW = width_of(H_RES * V_RES);
  localparam int SW = width_of(NUM_IMG);
  localparam logic [COLOUR_W-1:0] KeyColour = COLOUR_W'(KEY_COL);
`ifdef BLIT_TRANSPARENT_EN
  localparam bit TransparentEn = 1'b1;
`else
  localparam bit TransparentEn = 1'b0;
`endif

  blit_state_e state_q, state_d;
  logic        accept;
  logic        issue;
  logic        stateBusy;
  logic        stateDone;
  logic        drainEmpty;

  logic [SW-1:0] romSel_q;
  logic [SW-1:0] selClamped;

  logic [XW-1:0] genX;
  logic [YW-1:0] genY;
  logic [AW-1:0] genAddr;
  logic          genLast;

  logic [ROM_LAT-1:0][XW-1:0] pipeX_q;
  logic [ROM_LAT-1:0][YW-1:0] pipeY_q;
  logic [ROM_LAT-1:0]         pipeValid_q;

  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;
  logic                outValid_q;
  logic                alignedValid;
  logic                keepPixel;

  blit_addr_gen #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(accept),
    .step_i (issue),
    .x_o    (genX),
    .y_o    (genY),
    .addr_o (genAddr),
    .last_o (genLast)
  );

  // The frame is only finished once nothing is left in the delay line and the
  // output stage has retired its pixel. The output stage tracks its own valid
  // so that key-coloured (unplotted) pixels do not shorten the frame.
  assign drainEmpty   = (pipeValid_q == '0) && !outValid_q;
  assign alignedValid = pipeValid_q[ROM_LAT-1];
  assign keepPixel    = !(TransparentEn && (rom_data_i == KeyColour));

  // Out-of-range image indices select the last image instead.
  always_comb begin
    selClamped = img_sel_i;
    if (32'(img_sel_i) >= NUM_IMG) begin
      selClamped = SW'(NUM_IMG - 1);
    end
  end

  // Controller next-state and decoded outputs. Busy and done come straight
  // from the state register, so busy drops in the very cycle done pulses.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    stateBusy = 1'b0;
    stateDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        issue     = 1'b1;
        stateBusy = 1'b1;
        if (genLast) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        stateBusy = 1'b1;
        if (drainEmpty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        stateDone = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the image index captured with an accepted start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      romSel_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        romSel_q <= selClamped;
      end
    end
  end

  // Coordinate delay line: stage 0 holds the pixel whose address the ROM is
  // sampling, the last stage lines up with rom_data_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipeValid_q <= '0;
      pipeX_q     <= '0;
      pipeY_q     <= '0;
    end else begin
      pipeValid_q[0] <= issue;
      pipeX_q[0]     <= genX;
      pipeY_q[0]     <= genY;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeX_q[i]     <= pipeX_q[i-1];
        pipeY_q[i]     <= pipeY_q[i-1];
      end
    end
  end

  // Registered VGA outputs. Coordinates and colour only move when a pixel is
  // actually plotted, so they hold the last written pixel otherwise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= alignedValid;
      plot_q     <= alignedValid && keepPixel;
      if (alignedValid && keepPixel) begin
        x_q      <= pipeX_q[ROM_LAT-1];
        y_q      <= pipeY_q[ROM_LAT-1];
        colour_q <= rom_data_i;
      end
    end
  end

  assign busy_o     = stateBusy;
  assign done_o     = stateDone;
  assign rom_addr_o = genAddr;
  assign rom_sel_o  = romSel_q;
  assign x_o        = x_q;
  assign y_o        = y_q;
  assign colour_o   = colour_q;
  assign plot_o     = plot_q;

endmodule
